button_cmd_gen: RTL and testbench

BUTTON_CMD_GEN -- requirements
Module: button_cmd_gen

---
 rtl/tetris_input_pkg.sv | 33 +++
 rtl/das_channel.sv | 88 ++++++++
 rtl/button_cmd_gen.sv | 146 ++++++++++++++
 tb/tb_button_cmd_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
// Shared definitions for the controller-to-command front end.
// Contents: command code enum (3-bit), controller button bit positions,
// command count, and the auto-repeat channel state enum.
package tetris_input_pkg;

  typedef enum logic [2:0] {
    CmdLeft     = 3'd0,
    CmdRight    = 3'd1,
    CmdSoftDrop = 3'd2,
    CmdHardDrop = 3'd3,
    CmdRotCw    = 3'd4,
    CmdRotCcw   = 3'd5,
    CmdPause    = 3'd6
  } cmd_e;

  localparam int unsigned NumCmds = 7;

  localparam int unsigned BtnA      = 0;
  localparam int unsigned BtnB      = 1;
  localparam int unsigned BtnSelect = 2;
  localparam int unsigned BtnStart  = 3;
  localparam int unsigned BtnUp     = 4;
  localparam int unsigned BtnDown   = 5;
  localparam int unsigned BtnLeft   = 6;
  localparam int unsigned BtnRight  = 7;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } das_state_e;

endpackage

// File: rtl/das_channel.sv
// Delayed-auto-shift channel: one button's IDLE/DELAY/REPEAT state machine.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   step         frame strobe; the FSM only advances on this
//   press        button went 0->1 this frame
//   held         button is pressed this frame
//   clear        force IDLE this frame without firing (conflict, pause, priming)
//   fire         one-cycle move request, valid together with step
// Parameters: Delay = frames before repeat starts (0 = repeat immediately),
//             Period = frames between repeats.
module das_channel
  import tetris_input_pkg::*;
#(
  parameter int unsigned Delay  = 16,
  parameter int unsigned Period = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic press,
  input  logic held,
  input  logic clear,
  output logic fire
);

  localparam int unsigned MaxCnt = (Delay > Period) ? Delay : Period;
  localparam int unsigned CntW   = (MaxCnt > 0) ? $clog2(MaxCnt + 1) : 1;

  das_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_dec;

  // Saturating decrement: the counter never wraps below zero.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);

  always_comb begin
    fire = 1'b0;
    if (step && !clear) begin
      case (state_q)
        StIdle:            fire = press;
        StDelay, StRepeat: fire = held && (cnt_dec == '0);
        default:           fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (step) begin
      if (clear) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (press) begin
              if (Delay > 0) begin
                state_q <= StDelay;
                cnt_q   <= CntW'(Delay);
              end else begin
                state_q <= StRepeat;
                cnt_q   <= CntW'(Period);
              end
            end
          end
          StDelay, StRepeat: begin
            if (!held) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_dec == '0) begin
              state_q <= StRepeat;
              cnt_q   <= CntW'(Period);
            end else begin
              cnt_q <= cnt_dec;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_cmd_gen.sv
// Converts per-frame controller samples into a stream of game commands.
// Ports:
//   clk, reset      40 MHz clock, asynchronous active-low reset
//   buttons[7:0]    controller state (A,B,Select,Start,Up,Down,Left,Right)
//   buttons_valid   one-cycle strobe per frame marking a fresh sample
//   cmd[2:0]        command code, lowest pending code issued first
//   cmd_valid       cmd holds a command
//   cmd_ready       consumer accepts cmd when cmd_valid && cmd_ready
//   paused          pause state
// Build option: define BUTTON_CMD_GEN_PAUSE_EN to enable the Start/PAUSE feature;
// without it Start is ignored and paused is tied low.
module button_cmd_gen
  import tetris_input_pkg::*;
#(
  parameter int unsigned DAS_FRAMES = 16,
  parameter int unsigned ARR_FRAMES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       buttons_valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       paused
);

  logic [7:0]         prev_q;
  logic               primed_q;
  logic [NumCmds-1:0] pending_q, pending_d;
  logic [NumCmds-1:0] new_ev, cand, acc_mask;
  logic [2:0]         cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               paused_q;
  logic [7:0]         press;
  logic               conflict, clr_vert, clr_horz;
  logic               fire_l, fire_r, fire_d;
  logic               accept;
  logic               unused_press;

  assign press    = buttons & ~prev_q;
  assign conflict = buttons[BtnLeft] & buttons[BtnRight];
  // The first frame after reset only primes prev_q, so channels stay idle.
  assign clr_vert = !primed_q || paused_q;
  assign clr_horz = clr_vert || conflict;

  das_channel #(.Delay(DAS_FRAMES), .Period(ARR_FRAMES)) u_left (
    .clk   (clk),
    .reset (reset),
    .step  (buttons_valid),
    .press (press[BtnLeft]),
    .held  (buttons[BtnLeft]),
    .clear (clr_horz),
    .fire  (fire_l)
  );

  das_channel #(.Delay(DAS_FRAMES), .Period(ARR_FRAMES)) u_right (
    .clk   (clk),
    .reset (reset),
    .step  (buttons_valid),
    .press (press[BtnRight]),
    .held  (buttons[BtnRight]),
    .clear (clr_horz),
    .fire  (fire_r)
  );

  das_channel #(.Delay(0), .Period(ARR_FRAMES)) u_down (
    .clk   (clk),
    .reset (reset),
    .step  (buttons_valid),
    .press (press[BtnDown]),
    .held  (buttons[BtnDown]),
    .clear (clr_vert),
    .fire  (fire_d)
  );

  always_comb begin
    new_ev = '0;
    if (buttons_valid && primed_q) begin
      new_ev[CmdLeft]     = fire_l;
      new_ev[CmdRight]    = fire_r;
      new_ev[CmdSoftDrop] = fire_d;
      new_ev[CmdHardDrop] = press[BtnUp];
      new_ev[CmdRotCw]    = press[BtnA];
      new_ev[CmdRotCcw]   = press[BtnB];
      if (paused_q) new_ev = '0;
`ifdef BUTTON_CMD_GEN_PAUSE_EN
      new_ev[CmdPause]    = press[BtnStart];
`endif
    end
  end

  assign accept   = cmd_valid_q & cmd_ready;
  assign acc_mask = accept ? (NumCmds'(1) << cmd_q) : '0;
  // Candidates exclude the bit just accepted; a same-cycle re-set still lands in pending_d.
  assign cand      = pending_q & ~acc_mask;
  assign pending_d = cand | new_ev;

  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    if (!cmd_valid_q || accept) begin
      cmd_valid_d = |cand;
      for (int i = NumCmds - 1; i >= 0; i--) begin
        if (cand[i]) cmd_d = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q      <= '0;
      primed_q    <= 1'b0;
      pending_q   <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      if (buttons_valid) begin
        prev_q   <= buttons;
        primed_q <= 1'b1;
      end
      pending_q   <= pending_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

`ifdef BUTTON_CMD_GEN_PAUSE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      paused_q <= 1'b0;
    end else if (accept && (cmd_q == CmdPause)) begin
      paused_q <= ~paused_q;
    end
  end
  assign unused_press = press[BtnSelect];
`else
  assign paused_q     = 1'b0;
  assign unused_press = ^{press[BtnSelect], press[BtnStart]};
`endif

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_button_cmd_gen.sv
// Self-checking bench for button_cmd_gen: directed scenarios plus random button
// traffic compared frame by frame against a run-length reference model.
module tb_button_cmd_gen;

  localparam int Das = 16;
  localparam int Arr = 6;
  localparam int FrameLen = 30;
  localparam int BA = 0, BB = 1, BStart = 3, BUp = 4, BDown = 5, BLeft = 6, BRight = 7;
  localparam int CLeft = 0, CRight = 1, CSoft = 2, CHard = 3, CCw = 4, CCcw = 5, CPause = 6;
`ifdef BUTTON_CMD_GEN_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons = '0;
  logic       buttons_valid = 1'b0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       paused;

  button_cmd_gen #(.DAS_FRAMES(Das), .ARR_FRAMES(Arr)) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .paused        (paused)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0, fnum = 0;
  int n_left = 0, n_right = 0, n_soft = 0;
  logic [2:0] acc_q[$];
  int         acc_t[$];
  logic [6:0] expm;

  // Reference model state: run length of each held channel, -1 when not running.
  logic [7:0] m_prev;
  bit         m_primed, m_paused;
  int         run_l, run_r, run_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int next_run(input int run, input bit held, input bit pe, input bit blk);
    if (blk || !held) return -1;
    if (run < 0) return pe ? 0 : -1;
    return run + 1;
  endfunction

  function automatic bit hfire(input int run);
    return (run == 0) || (run >= Das && ((run - Das) % Arr) == 0);
  endfunction

  task automatic model_reset();
    m_prev = '0; m_primed = 0; m_paused = 0;
    run_l = -1; run_r = -1; run_d = -1;
  endtask

  task automatic model_frame(input logic [7:0] b, output logic [6:0] ev);
    logic [7:0] pe;
    bit blk, both;
    pe   = b & ~m_prev;
    blk  = !m_primed || m_paused;
    both = b[BLeft] && b[BRight];
    ev   = '0;
    run_l = next_run(run_l, b[BLeft], pe[BLeft], blk || both);
    run_r = next_run(run_r, b[BRight], pe[BRight], blk || both);
    run_d = next_run(run_d, b[BDown], pe[BDown], blk);
    if (!blk) begin
      ev[CLeft]  = hfire(run_l);
      ev[CRight] = hfire(run_r);
      ev[CSoft]  = (run_d >= 0) && ((run_d % Arr) == 0);
      ev[CHard]  = pe[BUp];
      ev[CCw]    = pe[BA];
      ev[CCcw]   = pe[BB];
    end
    if (PauseEn && m_primed && pe[BStart]) ev[CPause] = 1'b1;
    m_prev = b; m_primed = 1;
  endtask

  // Acceptance logger and stall-stability monitor.
  initial begin
    bit stall_prev;
    logic [2:0] prev_cmd;
    stall_prev = 0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stall_prev) check("stall_hold", {cmd_valid, cmd}, {1'b1, prev_cmd});
        if (cmd_valid && cmd_ready) begin
          acc_q.push_back(cmd);
          acc_t.push_back(cyc);
        end
        stall_prev = cmd_valid && !cmd_ready;
        prev_cmd   = cmd;
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    buttons_valid = 1'b0;
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_paused", paused, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // stall < 0: random ready for most of the frame, then forced high to drain.
  task automatic run_frame(input logic [7:0] b, input bit chk_lat, input int stall);
    logic [6:0] em, got_m;
    bit ordered;
    int last;
    model_frame(b, em);
    acc_q.delete(); acc_t.delete();
    for (int i = 0; i < FrameLen; i++) begin
      @(posedge clk); #1;
      buttons = b;
      buttons_valid = (i == 0);
      if (stall >= 0) cmd_ready = (i >= stall);
      else cmd_ready = (i >= 20) ? 1'b1 : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (chk_lat && i == 1) check("lat_c1_valid", cmd_valid, 0);
      if (chk_lat && i == 2) begin
        check("lat_c2_valid", cmd_valid, 1);
        check("lat_c2_cmd", cmd, CLeft);
      end
    end
    #1;
    got_m = '0; ordered = 1; last = -1;
    foreach (acc_q[k]) begin
      if (int'(acc_q[k]) <= last) ordered = 0;
      last = int'(acc_q[k]);
      if (acc_q[k] < 3'd7) got_m[acc_q[k]] = 1'b1;
    end
    check($sformatf("f%0d_cmds", fnum), got_m, em);
    check($sformatf("f%0d_order", fnum), ordered, 1);
    check($sformatf("f%0d_count", fnum), acc_q.size(), $countones(em));
    if (em[CPause]) m_paused = !m_paused;
    check($sformatf("f%0d_paused", fnum), paused, m_paused);
    if (got_m[CLeft]) n_left++;
    if (got_m[CRight]) n_right++;
    if (got_m[CSoft]) n_soft++;
    fnum++;
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    apply_reset();
    run_frame(8'h00, 0, -1);

    // Single tap of Left: one move, valid two cycles after the strobe.
    n_left = 0;
    run_frame(8'h40, 1, 0);
    run_frame(8'h00, 0, -1);
    check("tap_left_count", n_left, 1);

    // Hold Right 41 frames: moves at 0,16,22,28,34,40.
    n_right = 0;
    for (int f = 0; f <= 40; f++) run_frame(8'h80, 0, -1);
    run_frame(8'h00, 0, -1);
    check("hold_right_count", n_right, 6);

    // A, B, Up together with a 10-cycle stall after valid rises.
    run_frame(8'h13, 0, 12);
    if (acc_t.size() == 3) check("burst_consecutive", acc_t[2] - acc_t[0], 2);
    else check("burst_accepts", acc_t.size(), 3);
    run_frame(8'h00, 0, -1);

    // Left held, Right added then released: no further Left until re-pressed.
    n_left = 0;
    for (int f = 0; f < 5; f++) run_frame(8'h40, 0, -1);
    for (int f = 0; f < 3; f++) run_frame(8'hC0, 0, -1);
    for (int f = 0; f < 20; f++) run_frame(8'h40, 0, -1);
    check("conflict_left_count", n_left, 1);
    run_frame(8'h00, 0, -1);
    run_frame(8'h40, 0, -1);
    check("repress_left_count", n_left, 2);
    run_frame(8'h00, 0, -1);

`ifdef BUTTON_CMD_GEN_PAUSE_EN
    run_frame(8'h08, 0, -1);
    check("pause_on", paused, 1);
    run_frame(8'h00, 0, -1);
    n_left = 0;
    run_frame(8'h40, 0, -1);
    run_frame(8'h00, 0, -1);
    check("paused_left_ignored", n_left, 0);
    run_frame(8'h08, 0, -1);
    check("pause_off", paused, 0);
    run_frame(8'h00, 0, -1);
`endif

    // Down held into repeat, reset while a SOFT_DROP is presented.
    for (int f = 0; f < 12; f++) run_frame(8'h20, 0, -1);
    model_frame(8'h20, expm);
    @(posedge clk); #1;
    buttons = 8'h20; buttons_valid = 1'b1; cmd_ready = 1'b0;
    @(posedge clk); #1;
    buttons_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", cmd_valid, expm[CSoft]);
    check("pre_rst_cmd", cmd, CSoft);
    apply_reset();
    n_soft = 0;
    for (int f = 0; f < 8; f++) run_frame(8'h20, 0, -1);
    check("held_through_reset", n_soft, 0);
    run_frame(8'h00, 0, -1);
    run_frame(8'h20, 0, -1);
    check("repress_down", n_soft, 1);
    run_frame(8'h00, 0, -1);

    // Random traffic; horizontal/down bits toggle rarely so holds reach repeat.
    b = '0;
    for (int f = 0; f < 150; f++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 99) < ((k == BLeft || k == BRight || k == BDown) ? 8 : 25))
          b[k] = ~b[k];
      end
      run_frame(b, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
